// File: rtl/wb_write_queue_if.sv
// Writeback request / regfile write-port bundle for wb_write_queue.
// slave = the queue itself, master = the MEM/WB producer plus regfile/decode side.
interface wb_write_queue_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
);
   logic                 in_valid_i;
   logic                 in_ready_o;
   logic [ADDR_W-1:0]    in_addr_i;
   logic [DATA_W-1:0]    in_data_i;
   logic                 hold_i;
   logic                 wEnable_o;
   logic [ADDR_W-1:0]    wAddr_o;
   logic [DATA_W-1:0]    wData_o;
   logic [2**ADDR_W-1:0] busy_o;
   logic                 empty_o;
   logic [ADDR_W-1:0]    fwd_addr_i;
   logic                 fwd_hit_o;
   logic [DATA_W-1:0]    fwd_data_o;

   modport slave (
      input  in_valid_i, in_addr_i, in_data_i, hold_i, fwd_addr_i,
      output in_ready_o, wEnable_o, wAddr_o, wData_o, busy_o, empty_o,
             fwd_hit_o, fwd_data_o
   );

   modport master (
      output in_valid_i, in_addr_i, in_data_i, hold_i, fwd_addr_i,
      input  in_ready_o, wEnable_o, wAddr_o, wData_o, busy_o, empty_o,
             fwd_hit_o, fwd_data_o
   );
endinterface

// File: rtl/wb_write_queue.sv
// In-order writeback FIFO feeding the regfile write port, with a per-register
// pending-write scoreboard. Define WB_FWD_EN to build the forwarding lookup.
module wb_write_queue #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 4
) (
   input logic clk,
   input logic rst,
   wb_write_queue_if.slave bus
);
   localparam int NREG = 2**ADDR_W;
   localparam int PW   = $clog2(DEPTH);
   localparam int CW   = $clog2(DEPTH+1);
   localparam int PCW  = $clog2(DEPTH+2);

   logic [ADDR_W-1:0] mem_addr_q [DEPTH];
   logic [ADDR_W-1:0] mem_addr_d [DEPTH];
   logic [DATA_W-1:0] mem_data_q [DEPTH];
   logic [DATA_W-1:0] mem_data_d [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              wen_q, wen_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              ret_v_q, ret_v_d;
   logic [ADDR_W-1:0] ret_a_q, ret_a_d;
   logic [PCW-1:0]    pend_q [NREG];
   logic [PCW-1:0]    pend_d [NREG];

   logic              ready;
   logic              accept;
   logic              push;
   logic              pop;

   assign ready  = (count_q < CW'(DEPTH));
   assign accept = bus.in_valid_i & ready;
   assign push   = accept & (bus.in_addr_i != '0);
   // An empty FIFO pops the entry being pushed this cycle directly.
   assign pop    = ~bus.hold_i & ((count_q != '0) | push);

   always_comb begin
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q + CW'(push) - CW'(pop);
      wen_d      = pop;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      ret_v_d    = wen_q;
      ret_a_d    = waddr_q;
      if (push) begin
         mem_addr_d[wr_ptr_q] = bus.in_addr_i;
         mem_data_d[wr_ptr_q] = bus.in_data_i;
         wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         if (count_q == '0) begin
            waddr_d = bus.in_addr_i;
            wdata_d = bus.in_data_i;
         end else begin
            waddr_d = mem_addr_q[rd_ptr_q];
            wdata_d = mem_data_q[rd_ptr_q];
         end
      end
   end

   // Retire lags the port by one cycle so busy covers the regfile forward window.
   always_comb begin
      for (int unsigned r = 0; r < NREG; r++) begin
         pend_d[r] = pend_q[r]
                   + PCW'(push && (bus.in_addr_i == ADDR_W'(r)))
                   - PCW'(ret_v_q && (ret_a_q == ADDR_W'(r)));
      end
   end

   always_ff @(posedge clk) begin
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         wen_q    <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         ret_v_q  <= 1'b0;
         ret_a_q  <= '0;
         for (int unsigned r = 0; r < NREG; r++) pend_q[r] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         wen_q    <= wen_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         ret_v_q  <= ret_v_d;
         ret_a_q  <= ret_a_d;
         pend_q   <= pend_d;
      end
   end

   always_comb begin
      for (int unsigned r = 0; r < NREG; r++) bus.busy_o[r] = (pend_q[r] != '0);
      bus.busy_o[0] = 1'b0;
   end

   assign bus.in_ready_o = ready;
   assign bus.wEnable_o  = wen_q;
   assign bus.wAddr_o    = waddr_q;
   assign bus.wData_o    = wdata_q;
   assign bus.empty_o    = (count_q == '0) & ~wen_q;

`ifdef WB_FWD_EN
   logic [PW-1:0] idx;

   // Walk oldest to newest so the youngest match overwrites older ones.
   always_comb begin
      bus.fwd_hit_o  = 1'b0;
      bus.fwd_data_o = '0;
      idx            = '0;
      if (bus.fwd_addr_i != '0) begin
         if (wen_q && (waddr_q == bus.fwd_addr_i)) begin
            bus.fwd_hit_o  = 1'b1;
            bus.fwd_data_o = wdata_q;
         end
         for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (mem_addr_q[idx] == bus.fwd_addr_i)) begin
               bus.fwd_hit_o  = 1'b1;
               bus.fwd_data_o = mem_data_q[idx];
            end
         end
      end
   end
`else
   logic unused_fwd_addr;
   assign unused_fwd_addr = ^bus.fwd_addr_i;
   assign bus.fwd_hit_o   = 1'b0;
   assign bus.fwd_data_o  = '0;
`endif
endmodule

// File: tb/tb_wb_write_queue.sv
// Directed and randomized checks of wb_write_queue against a queue-based model.
module tb_wb_write_queue;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 4;

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } ent_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   wb_write_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   wb_write_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: pending entries, the port register and the previous port value.
   ent_t              q [$];
   logic              m_wen, m_pwen;
   logic [ADDR_W-1:0] m_waddr, m_paddr;
   logic [DATA_W-1:0] m_wdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_check();
      logic [15:0]       eb;
      logic              eh;
      logic [DATA_W-1:0] ed;
      eb = '0;
      foreach (q[k]) eb[q[k].a] = 1'b1;
      if (m_wen)  eb[m_waddr] = 1'b1;
      if (m_pwen) eb[m_paddr] = 1'b1;
      eb[0] = 1'b0;
      eh = 1'b0;
      ed = '0;
`ifdef WB_FWD_EN
      if (bus.fwd_addr_i != '0) begin
         if (m_wen && m_waddr == bus.fwd_addr_i) begin
            eh = 1'b1;
            ed = m_wdata;
         end
         foreach (q[k]) if (q[k].a == bus.fwd_addr_i) begin
            eh = 1'b1;
            ed = q[k].d;
         end
      end
`endif
      chk("ready", 32'(bus.in_ready_o), 32'(q.size() < DEPTH));
      chk("empty", 32'(bus.empty_o), 32'(q.size() == 0 && !m_wen));
      chk("wen",   32'(bus.wEnable_o), 32'(m_wen));
      chk("waddr", 32'(bus.wAddr_o), 32'(m_waddr));
      chk("wdata", 32'(bus.wData_o), 32'(m_wdata));
      chk("busy",  32'(bus.busy_o), 32'(eb));
      chk("fhit",  32'(bus.fwd_hit_o), 32'(eh));
      chk("fdata", 32'(bus.fwd_data_o), 32'(ed));
   endtask

   task automatic drive(input logic r, input logic v, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic h,
                        input logic [ADDR_W-1:0] fa);
      @(negedge clk);
      rst            = r;
      bus.in_valid_i = v;
      bus.in_addr_i  = a;
      bus.in_data_i  = d;
      bus.hold_i     = h;
      bus.fwd_addr_i = fa;
      #1;
      model_check();
   endtask

   task automatic tick();
      ent_t e;
      logic acc;
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_wen = 0; m_pwen = 0; m_waddr = '0; m_paddr = '0; m_wdata = '0;
      end else begin
         acc    = bus.in_valid_i && (q.size() < DEPTH);
         m_pwen = m_wen;
         m_paddr = m_waddr;
         if (acc && bus.in_addr_i != '0) begin
            e.a = bus.in_addr_i;
            e.d = bus.in_data_i;
            q.push_back(e);
         end
         if (!bus.hold_i && q.size() > 0) begin
            e = q.pop_front();
            m_wen = 1; m_waddr = e.a; m_wdata = e.d;
         end else begin
            m_wen = 0;
         end
      end
   endtask

   task automatic idle(input logic h);
      drive(0, 0, '0, '0, h, '0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      q.delete();
      m_wen = 0; m_pwen = 0; m_waddr = '0; m_paddr = '0; m_wdata = '0;
      rst = 1;
      bus.in_valid_i = 0; bus.in_addr_i = '0; bus.in_data_i = '0;
      bus.hold_i = 0; bus.fwd_addr_i = '0;
      @(posedge clk);
      drive(1, 0, '0, '0, 0, '0); tick();
      drive(1, 0, '0, '0, 0, '0); tick();

      // Reset state, then single write r3
      drive(0, 1, 4'd3, 16'h1234, 0, '0);
      chk("rst_busy", 32'(bus.busy_o), 32'h0);
      chk("rst_empty", 32'(bus.empty_o), 32'h1);
      chk("rst_wen", 32'(bus.wEnable_o), 32'h0);
      chk("t1_ready", 32'(bus.in_ready_o), 32'h1);
      tick();
      idle(0);
      chk("t1_wen", 32'(bus.wEnable_o), 32'h1);
      chk("t1_addr", 32'(bus.wAddr_o), 32'h3);
      chk("t1_data", 32'(bus.wData_o), 32'h1234);
      chk("t1_busy_a", 32'(bus.busy_o[3]), 32'h1);
      tick();
      idle(0);
      chk("t1_busy_b", 32'(bus.busy_o[3]), 32'h1);
      tick();
      idle(0);
      chk("t1_busy_c", 32'(bus.busy_o[3]), 32'h0);
      tick();

      // Held fill to full, stalled 5th offer, then ordered drain
      for (int i = 1; i <= 4; i++) begin
         drive(0, 1, ADDR_W'(i), DATA_W'(i * 'h11), 1, '0);
         tick();
      end
      drive(0, 1, 4'd5, 16'h0055, 1, '0);
      chk("t2_full", 32'(bus.in_ready_o), 32'h0);
      tick();
      idle(0); tick();
      for (int i = 1; i <= 4; i++) begin
         idle(0);
         chk("t2_wen", 32'(bus.wEnable_o), 32'h1);
         chk("t2_addr", 32'(bus.wAddr_o), 32'(i));
         chk("t2_data", 32'(bus.wData_o), 32'(i * 'h11));
         tick();
      end
      idle(0);
      chk("t2_done", 32'(bus.wEnable_o), 32'h0);
      tick();
      idle(0); tick();

      // Write to register 0 is dropped
      drive(0, 1, 4'd0, 16'hFFFF, 0, '0);
      chk("t3_ready", 32'(bus.in_ready_o), 32'h1);
      tick();
      idle(0);
      chk("t3_wen", 32'(bus.wEnable_o), 32'h0);
      chk("t3_busy", 32'(bus.busy_o), 32'h0);
      chk("t3_empty", 32'(bus.empty_o), 32'h1);
      tick();

      // Full FIFO, continuous offers while draining across pointer wrap
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, ADDR_W'($urandom_range(1, 15)), DATA_W'($urandom), 1, '0);
         tick();
      end
      for (int i = 0; i < 12; i++) begin
         drive(0, 1, ADDR_W'($urandom_range(1, 15)), DATA_W'($urandom), 0,
               ADDR_W'($urandom_range(0, 15)));
         tick();
      end
      for (int i = 0; i < 7; i++) begin idle(0); tick(); end

      // Two pending writes to r5: youngest forwards
      drive(0, 1, 4'd5, 16'hAAAA, 1, '0); tick();
      drive(0, 1, 4'd5, 16'hBBBB, 1, '0); tick();
      drive(0, 0, '0, '0, 1, 4'd5);
`ifdef WB_FWD_EN
      chk("t5_hit", 32'(bus.fwd_hit_o), 32'h1);
      chk("t5_data", 32'(bus.fwd_data_o), 32'hBBBB);
`else
      chk("t5_hit", 32'(bus.fwd_hit_o), 32'h0);
      chk("t5_data", 32'(bus.fwd_data_o), 32'h0);
`endif
      chk("t5_busy", 32'(bus.busy_o[5]), 32'h1);
      tick();
      drive(0, 1, 4'd7, 16'h7777, 1, '0); tick();

      // Reset with three entries queued
      drive(1, 0, '0, '0, 0, '0); tick();
      idle(0);
      chk("t6_busy", 32'(bus.busy_o), 32'h0);
      chk("t6_empty", 32'(bus.empty_o), 32'h1);
      chk("t6_wen", 32'(bus.wEnable_o), 32'h0);
      chk("t6_addr", 32'(bus.wAddr_o), 32'h0);
      chk("t6_data", 32'(bus.wData_o), 32'h0);
      tick();
      for (int i = 0; i < 3; i++) begin
         idle(0);
         chk("t6_quiet", 32'(bus.wEnable_o), 32'h0);
         tick();
      end

      // Random traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 63) == 0), $urandom_range(0, 3) != 0,
               ADDR_W'($urandom_range(0, 6)), DATA_W'($urandom),
               $urandom_range(0, 3) == 0, ADDR_W'($urandom_range(0, 6)));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
